// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// register_bank : NREG x N register file, x0 hardwired to zero, two
//                 registered read ports with same-cycle write bypass.
// Revision      : 1.0
// ============================================================================
module register_bank #(
  parameter int N      = 8,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] rd,
  input  logic [N-1:0]      writeData,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [N-1:0]      dataA,
  output logic [N-1:0]      dataB,
  output logic              opValid
);

  localparam logic [ADDR_W:0] c_nreg = (ADDR_W + 1)'(NREG);

  logic [N-1:0] regs_q [NREG];
  logic [N-1:0] regs_d [NREG];
  logic [N-1:0] dataA_q, dataA_d;
  logic [N-1:0] dataB_q, dataB_d;
  logic         opValid_q, opValid_d;
  logic         w_write_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] r);
    return ({1'b0, r} < c_nreg);
  endfunction

  // Operand source priority: x0/out-of-range, then bypass, then stored value.
  function automatic logic [N-1:0] src(
    input logic [ADDR_W-1:0] r,
    input logic [N-1:0]      stored
  );
    logic [N-1:0] v;
    if (r == '0 || !in_range(r))
      v = '0;
    else if (RegWrite && rd == r)
      v = writeData;
    else
      v = stored;
    return v;
  endfunction

  assign w_write_ok = RegWrite && (rd != '0) && in_range(rd);

  always_comb begin
    regs_d = regs_q;
    if (w_write_ok)
      regs_d[rd] = writeData;
    regs_d[0] = '0;

    dataA_d   = dataA_q;
    dataB_d   = dataB_q;
    opValid_d = readEn;
    if (readEn) begin
      dataA_d = src(rs1, regs_q[rs1]);
      dataB_d = src(rs2, regs_q[rs2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
      dataA_q   <= '0;
      dataB_q   <= '0;
      opValid_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      dataA_q   <= dataA_d;
      dataB_q   <= dataB_d;
      opValid_q <= opValid_d;
    end
  end

  assign dataA   = dataA_q;
  assign dataB   = dataB_q;
  assign opValid = opValid_q;

endmodule
`default_nettype wire
